sr_latch_ctrl: RTL and testbench

SR_LATCH_CTRL -- requirements
Module: sr_latch_ctrl

---
 rtl/sr_latch_ctrl.sv | 140 ++++++++++++++
 tb/tb_sr_latch_ctrl.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sr_latch_ctrl.sv
// Two-requester arbiter that drives set/reset pulses to an external SR latch bank
// and keeps a shadow copy of the latched values.
module sr_latch_ctrl #(
   parameter int unsigned N_FLAGS = 4,
   parameter int unsigned IDX_W   = 3
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [1:0]         req,
   input  logic [1:0]         op,
   input  logic [IDX_W-1:0]   idx_a,
   input  logic [IDX_W-1:0]   idx_b,
   output logic [1:0]         gnt,
   output logic [1:0]         done,
   output logic               err,
   output logic [N_FLAGS-1:0] s_out,
   output logic [N_FLAGS-1:0] r_out,
   output logic [N_FLAGS-1:0] flags,
   output logic               busy
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] GRANT = 2'd1;
   localparam logic [1:0] DRIVE = 2'd2;
   localparam logic [1:0] DONE  = 2'd3;

   logic [1:0]         state,    state_nxt;
   logic               last_b,   last_b_nxt;
   logic               win_b,    win_b_nxt;
   logic               cap_op,   cap_op_nxt;
   logic [IDX_W-1:0]   cap_idx,  cap_idx_nxt;
   logic [1:0]         gnt_nxt;
   logic [1:0]         done_nxt;
   logic               err_nxt;
   logic [N_FLAGS-1:0] s_nxt;
   logic [N_FLAGS-1:0] r_nxt;
   logic [N_FLAGS-1:0] flags_nxt;
   logic               busy_nxt;

   logic [N_FLAGS-1:0] idx_mask_c;
   logic               idx_valid_c;
   logic               pick_b_c;

   // One-hot decode of the captured index; an out-of-range index decodes to zero.
   always_comb begin
      idx_mask_c = '0;
      for (int unsigned i = 0; i < N_FLAGS; i++) begin
         if (32'(cap_idx) == i) idx_mask_c[i] = 1'b1;
      end
      idx_valid_c = |idx_mask_c;
   end

   // B wins when it is alone, or on a tie when A was the last winner.
   assign pick_b_c = req[1] & (~req[0] | ~last_b);

   // Next-state and registered-output logic.
   always_comb begin
      state_nxt   = state;
      last_b_nxt  = last_b;
      win_b_nxt   = win_b;
      cap_op_nxt  = cap_op;
      cap_idx_nxt = cap_idx;
      flags_nxt   = flags;
      gnt_nxt     = 2'b00;
      done_nxt    = 2'b00;
      err_nxt     = 1'b0;
      s_nxt       = '0;
      r_nxt       = '0;

      case (state)
         IDLE: begin
            if (req != 2'b00) begin
               state_nxt   = GRANT;
               win_b_nxt   = pick_b_c;
               last_b_nxt  = pick_b_c;
               cap_op_nxt  = pick_b_c ? op[1] : op[0];
               cap_idx_nxt = pick_b_c ? idx_b : idx_a;
               gnt_nxt     = {pick_b_c, ~pick_b_c};
            end
         end
         GRANT: begin
            state_nxt = DRIVE;
            if (idx_valid_c) begin
               if (cap_op) begin
                  s_nxt     = idx_mask_c;
                  flags_nxt = flags | idx_mask_c;
               end else begin
                  r_nxt     = idx_mask_c;
                  flags_nxt = flags & ~idx_mask_c;
               end
            end
         end
         DRIVE: begin
            state_nxt = DONE;
            done_nxt  = {win_b, ~win_b};
            err_nxt   = ~idx_valid_c;
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase

      busy_nxt = (state_nxt != IDLE);
   end

   // State and output registers; reset leaves the pointer on B so A wins the first tie.
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         last_b  <= 1'b1;
         win_b   <= 1'b0;
         cap_op  <= 1'b0;
         cap_idx <= '0;
         gnt     <= 2'b00;
         done    <= 2'b00;
         err     <= 1'b0;
         s_out   <= '0;
         r_out   <= '0;
         flags   <= '0;
         busy    <= 1'b0;
      end else begin
         state   <= state_nxt;
         last_b  <= last_b_nxt;
         win_b   <= win_b_nxt;
         cap_op  <= cap_op_nxt;
         cap_idx <= cap_idx_nxt;
         gnt     <= gnt_nxt;
         done    <= done_nxt;
         err     <= err_nxt;
         s_out   <= s_nxt;
         r_out   <= r_nxt;
         flags   <= flags_nxt;
         busy    <= busy_nxt;
      end
   end

endmodule

// File: tb/tb_sr_latch_ctrl.sv
// Scoreboard bench for sr_latch_ctrl: a transaction-level model predicts grant order,
// drive pulses, completion and shadow flags; a monitor checks the DUT against it.
module tb_sr_latch_ctrl;

   localparam int unsigned N     = 4;
   localparam int unsigned IDX_W = 3;

   logic             clk = 1'b0;
   logic             reset;
   logic [1:0]       req;
   logic [1:0]       op;
   logic [IDX_W-1:0] idx_a;
   logic [IDX_W-1:0] idx_b;
   logic [1:0]       gnt;
   logic [1:0]       done;
   logic             err;
   logic [N-1:0]     s_out;
   logic [N-1:0]     r_out;
   logic [N-1:0]     flags;
   logic             busy;

   sr_latch_ctrl #(.N_FLAGS(N), .IDX_W(IDX_W)) dut (
      .clk(clk), .reset(reset), .req(req), .op(op), .idx_a(idx_a), .idx_b(idx_b),
      .gnt(gnt), .done(done), .err(err), .s_out(s_out), .r_out(r_out),
      .flags(flags), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]   gnt;
      logic [N-1:0] s;
      logic [N-1:0] r;
      logic         err;
      logic [N-1:0] flags;
   } exp_t;

   exp_t sbq[$];
   bit   mflag[N];
   int   last_win = 1;   // 0 = A, 1 = B
   bit   mon_en = 1'b1;
   int   n_pass = 0;
   int   n_total = 0;

   task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
   endtask

   // Model: one operation by requester `who`, appended in execution order.
   task automatic push_op(int who, bit o, int ix);
      exp_t e;
      e.gnt = (who == 0) ? 2'b01 : 2'b10;
      e.s   = '0;
      e.r   = '0;
      e.err = (ix >= int'(N));
      if (!e.err) begin
         if (o) e.s = 4'(32'd1 << ix);
         else   e.r = 4'(32'd1 << ix);
         mflag[ix] = o;
      end
      for (int i = 0; i < int'(N); i++) e.flags[i] = mflag[i];
      last_win = who;
      sbq.push_back(e);
   endtask

   task automatic model_reset();
      for (int i = 0; i < int'(N); i++) mflag[i] = 1'b0;
      last_win = 1;
   endtask

   task automatic check_inv();
      check("sr_overlap", 32'(s_out & r_out), 32'd0);
      check("drive_onehot", 32'($countones(s_out | r_out) <= 1), 32'd1);
   endtask

   task automatic check_all_zero(string tag);
      check({tag, "_gnt"},   32'(gnt),   32'd0);
      check({tag, "_done"},  32'(done),  32'd0);
      check({tag, "_err"},   32'(err),   32'd0);
      check({tag, "_s_out"}, 32'(s_out), 32'd0);
      check({tag, "_r_out"}, 32'(r_out), 32'd0);
      check({tag, "_flags"}, 32'(flags), 32'd0);
      check({tag, "_busy"},  32'(busy),  32'd0);
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 20) begin
         @(posedge clk); #1; n++;
      end
      if (busy) check("idle_timeout", 32'd1, 32'd0);
   endtask

   task automatic do_reset();
      wait_idle();
      @(posedge clk); #1;
      reset = 1'b1;
      req   = 2'b00;
      @(posedge clk); #1;
      reset = 1'b0;
      check_all_zero("reset");
      model_reset();
   endtask

   // One round from idle: raise the enabled requests, drop each at its grant.
   task automatic do_round(bit ea, bit oa, int ia, bit eb, bit ob, int ib);
      bit pend_a, pend_b;
      int got, waited;
      if (ea && eb) begin
         if (last_win == 1) begin push_op(0, oa, ia); push_op(1, ob, ib); end
         else               begin push_op(1, ob, ib); push_op(0, oa, ia); end
      end else if (ea) push_op(0, oa, ia);
      else if (eb)     push_op(1, ob, ib);
      @(posedge clk); #1;
      req    = {eb, ea};
      op     = {ob, oa};
      idx_a  = IDX_W'(ia);
      idx_b  = IDX_W'(ib);
      pend_a = ea;
      pend_b = eb;
      got    = 0;
      waited = 0;
      while ((pend_a || pend_b) && waited < 40) begin
         @(posedge clk); #1; waited++;
         if (gnt[0] && pend_a) begin
            req[0] = 1'b0; pend_a = 1'b0; got++;
            check(got == 1 ? "lat_first" : "lat_second", 32'(waited), got == 1 ? 32'd1 : 32'd5);
         end
         if (gnt[1] && pend_b) begin
            req[1] = 1'b0; pend_b = 1'b0; got++;
            check(got == 1 ? "lat_first" : "lat_second", 32'(waited), got == 1 ? 32'd1 : 32'd5);
         end
      end
      if (pend_a || pend_b) begin
         check("grant_timeout", 32'd1, 32'd0);
         req = 2'b00;
      end
      wait_idle();
   endtask

   // Both requesters keep requesting, renewing op/idx in their grant cycle.
   task automatic both_held(int nops);
      int issued, grants, waited, w, exp_w, ia, ib;
      bit oa, ob;
      oa = 1'($urandom); ia = $urandom_range(0, 7);
      ob = 1'($urandom); ib = $urandom_range(0, 7);
      exp_w = (last_win == 1) ? 0 : 1;
      if (exp_w == 0) begin push_op(0, oa, ia); push_op(1, ob, ib); end
      else            begin push_op(1, ob, ib); push_op(0, oa, ia); end
      @(posedge clk); #1;
      req = 2'b11; op = {ob, oa}; idx_a = IDX_W'(ia); idx_b = IDX_W'(ib);
      issued = 2; grants = 0; waited = 0;
      while (grants < nops && waited < 200) begin
         @(posedge clk); #1; waited++;
         if (gnt != 2'b00) begin
            w = gnt[1] ? 1 : 0;
            grants++;
            check("rr_alternate", 32'(w), 32'(exp_w));
            exp_w = 1 - w;
            if (issued < nops) begin
               oa = 1'($urandom); ia = $urandom_range(0, 7);
               push_op(w, oa, ia);
               op[w] = oa;
               if (w == 0) idx_a = IDX_W'(ia);
               else        idx_b = IDX_W'(ia);
               issued++;
            end else begin
               req[w] = 1'b0;
            end
         end
      end
      if (grants < nops) check("held_timeout", 32'd1, 32'd0);
      req = 2'b00;
      wait_idle();
   endtask

   // Monitor: pops an expectation at every grant and follows it through drive and done.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (mon_en) begin
            check_inv();
            if (gnt != 2'b00) begin
               if (sbq.size() == 0) begin
                  check("unexpected_gnt", 32'(gnt), 32'd0);
               end else begin
                  e = sbq.pop_front();
                  check("gnt", 32'(gnt), 32'(e.gnt));
                  check("busy_in_op", 32'(busy), 32'd1);
                  @(negedge clk);
                  check_inv();
                  check("drive_s", 32'(s_out), 32'(e.s));
                  check("drive_r", 32'(r_out), 32'(e.r));
                  check("flags", 32'(flags), 32'(e.flags));
                  check("gnt_one_cycle", 32'(gnt), 32'd0);
                  @(negedge clk);
                  check_inv();
                  check("done", 32'(done), 32'(e.gnt));
                  check("err", 32'(err), 32'(e.err));
                  check("done_no_drive", 32'(s_out | r_out), 32'd0);
               end
            end else begin
               check("idle_quiet", 32'({err, done, s_out | r_out}), 32'd0);
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int sel;
      reset = 1'b1;
      req   = 2'b01;
      op    = 2'b01;
      idx_a = 3'd2;
      idx_b = 3'd0;
      model_reset();
      push_op(0, 1'b1, 2);
      @(posedge clk); #1;
      check_all_zero("reset");
      reset = 1'b0;
      @(posedge clk); #1;
      check("first_edge_gnt", 32'(gnt), 32'd1);
      req = 2'b00;
      wait_idle();

      do_reset();
      do_round(1'b1, 1'b1, 1, 1'b1, 1'b0, 1);
      check("same_flag_final", 32'(flags[1]), 32'd0);
      do_round(1'b0, 1'b0, 0, 1'b1, 1'b1, 5);
      do_round(1'b1, 1'b0, 2, 1'b0, 1'b0, 0);
      do_round(1'b1, 1'b0, 2, 1'b0, 1'b0, 0);
      both_held(8);

      for (int k = 0; k < 30; k++) begin
         sel = $urandom_range(1, 3);
         do_round(1'(sel & 1), 1'($urandom), $urandom_range(0, 7),
                  1'(sel >> 1), 1'($urandom), $urandom_range(0, 7));
      end

      // Abort a set to flag 3 with reset during its drive cycle.
      mon_en = 1'b0;
      @(posedge clk); #1;
      req = 2'b01; op = 2'b01; idx_a = 3'd3;
      @(posedge clk); #1;
      check("abort_gnt", 32'(gnt), 32'd1);
      req = 2'b00;
      @(posedge clk); #1;
      check("abort_drive", 32'(s_out), 32'h8);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      check_all_zero("abort");
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         check("abort_silent", 32'({gnt, done, s_out | r_out}), 32'd0);
      end
      model_reset();
      mon_en = 1'b1;
      do_round(1'b1, 1'b1, 0, 1'b0, 1'b0, 0);

      repeat (2) @(posedge clk);
      check("sb_drained", 32'(sbq.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
